// File: rtl/elevator_shaft_model_if.sv
// elevator_shaft_model_if: command/sensor bundle between elevator controller and shaft plant model
// master (controller): drives up/down/stop/open_door, reads S1..S4/floor/moving/door_closed/fault
// slave  (plant):      reads commands, drives sensors and status
// SHAFT_TRIP_COUNT_EN adds trips[7:0] (plant -> controller)
interface elevator_shaft_model_if;
    logic       up, down, stop, open_door;
    logic       S1, S2, S3, S4;
    logic [1:0] floor;
    logic       moving, door_closed, fault;
`ifdef SHAFT_TRIP_COUNT_EN
    logic [7:0] trips;
    modport master (output up, down, stop, open_door,
                    input  S1, S2, S3, S4, floor, moving, door_closed, fault, trips);
    modport slave  (input  up, down, stop, open_door,
                    output S1, S2, S3, S4, floor, moving, door_closed, fault, trips);
`else
    modport master (output up, down, stop, open_door,
                    input  S1, S2, S3, S4, floor, moving, door_closed, fault);
    modport slave  (input  up, down, stop, open_door,
                    output S1, S2, S3, S4, floor, moving, door_closed, fault);
`endif
endinterface

// File: rtl/elevator_shaft_model.sv
// elevator_shaft_model: cycle-accurate 4-floor car and door plant model
// clk   : rising-edge clock
// reset : synchronous active-low reset
// bus   : slave side of elevator_shaft_model_if (motor/door commands in, floor sensors/status out)
// SHAFT_TRIP_COUNT_EN: when defined, adds bus.trips, a saturating count of floor arrivals
module elevator_shaft_model #(
    parameter int TRAVEL_CYCLES = 8,
    parameter int DOOR_CYCLES   = 4,
    parameter int START_FLOOR   = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    elevator_shaft_model_if.slave  bus
);
    localparam int PW = $clog2(3 * TRAVEL_CYCLES + 1);
    localparam int CW = $clog2(DOOR_CYCLES + 1);
    localparam logic [PW-1:0] TOP = PW'(3 * TRAVEL_CYCLES);
    localparam logic [CW-1:0] DC  = CW'(DOOR_CYCLES);
    localparam logic [CW-1:0] DL  = CW'(DOOR_CYCLES - 1);

    typedef enum logic [1:0] {CLOSED, OPENING, OPEN, CLOSING} door_t;

    logic [PW-1:0] pos_q, pos_d;
    door_t         door_q, door_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    s_q, s_d;
    logic [1:0]    floor_q, floor_d;
    logic          moving_q, moving_d, door_closed_q, door_closed_d, fault_q, fault_d;
    logic          req_up, req_dn, go_up, go_dn, step;
`ifdef SHAFT_TRIP_COUNT_EN
    logic [7:0]    trips_q, trips_d;
`endif

    always_comb begin
        req_up   = !bus.stop && bus.up && !bus.down;
        req_dn   = !bus.stop && bus.down && !bus.up;
        go_up    = req_up && door_q == CLOSED && pos_q != TOP;
        go_dn    = req_dn && door_q == CLOSED && pos_q != '0;
        step     = go_up || go_dn;
        pos_d    = go_up ? pos_q + 1'b1 : go_dn ? pos_q - 1'b1 : pos_q;
        moving_d = step;
        // any requested step that cannot be taken, or a conflicting up+down, is illegal
        fault_d  = fault_q || (!bus.stop && bus.up && bus.down) || ((req_up || req_dn) && !step);
        floor_d  = floor_q;
        for (int k = 0; k < 4; k++) begin
            s_d[k] = pos_d == PW'(k * TRAVEL_CYCLES);
            if (s_d[k]) floor_d = 2'(k);
        end
        door_d = door_q;
        cnt_d  = cnt_q;
        // reversals preload the counter with the time already spent so no time is lost
        case (door_q)
            CLOSED:  if (bus.open_door && |s_q && !step) begin
                         door_d = OPENING;
                         cnt_d  = '0;
                     end
            OPENING: if (!bus.open_door) begin
                         door_d = CLOSING;
                         cnt_d  = DC - cnt_q;
                     end else if (cnt_q >= DL) begin
                         door_d = OPEN;
                         cnt_d  = '0;
                     end else cnt_d = cnt_q + 1'b1;
            OPEN:    if (!bus.open_door) begin
                         door_d = CLOSING;
                         cnt_d  = '0;
                     end
            CLOSING: if (bus.open_door) begin
                         door_d = OPENING;
                         cnt_d  = DC - cnt_q;
                     end else if (cnt_q >= DL) begin
                         door_d = CLOSED;
                         cnt_d  = '0;
                     end else cnt_d = cnt_q + 1'b1;
            default: door_d = CLOSED;
        endcase
        door_closed_d = door_d == CLOSED;
`ifdef SHAFT_TRIP_COUNT_EN
        trips_d = (step && |s_d && trips_q != 8'hFF) ? trips_q + 8'd1 : trips_q;
`endif
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pos_q         <= PW'(START_FLOOR * TRAVEL_CYCLES);
            door_q        <= CLOSED;
            cnt_q         <= '0;
            s_q           <= 4'(1 << START_FLOOR);
            floor_q       <= 2'(START_FLOOR);
            moving_q      <= 1'b0;
            door_closed_q <= 1'b1;
            fault_q       <= 1'b0;
`ifdef SHAFT_TRIP_COUNT_EN
            trips_q       <= '0;
`endif
        end else begin
            pos_q         <= pos_d;
            door_q        <= door_d;
            cnt_q         <= cnt_d;
            s_q           <= s_d;
            floor_q       <= floor_d;
            moving_q      <= moving_d;
            door_closed_q <= door_closed_d;
            fault_q       <= fault_d;
`ifdef SHAFT_TRIP_COUNT_EN
            trips_q       <= trips_d;
`endif
        end
    end

    assign bus.S1          = s_q[0];
    assign bus.S2          = s_q[1];
    assign bus.S3          = s_q[2];
    assign bus.S4          = s_q[3];
    assign bus.floor       = floor_q;
    assign bus.moving      = moving_q;
    assign bus.door_closed = door_closed_q;
    assign bus.fault       = fault_q;
`ifdef SHAFT_TRIP_COUNT_EN
    assign bus.trips       = trips_q;
`endif
endmodule
